// File: rtl/chiplet_pkg.sv
// Shared chiplet link definitions: flit header layout, command/length codes,
// and the parser state encoding. Used by both the RX parser and TX packetizer.
package chiplet_pkg;

    localparam int FLIT_W        = 40;
    localparam int WORD_W        = 32;
    localparam int MAX_PKT_WORDS = 32;
    localparam int CNT_W         = 6;
    localparam int CMD_W         = 3;
    localparam int LEN_W         = 3;
    localparam int ID_W          = 6;

    // Header bit positions
    localparam int MODE_BIT    = 0;
    localparam int VALID_BIT   = 1;
    localparam int CMD_LSB     = 2;
    localparam int LEN_LSB     = 5;
    localparam int TID_LSB     = 8;
    localparam int DID_LSB     = 14;
    localparam int LW_ADDR_LSB = 8;

    typedef enum logic [CMD_W-1:0] {
        CMD_RD_REQ = 3'b000,
        CMD_WR_REQ = 3'b001,
        CMD_RD_RSP = 3'b010
    } cmd_e;

    // Length codes: payload bytes = 4 << code
    localparam logic [LEN_W-1:0] LEN_4B   = 3'b000;
    localparam logic [LEN_W-1:0] LEN_8B   = 3'b001;
    localparam logic [LEN_W-1:0] LEN_16B  = 3'b010;
    localparam logic [LEN_W-1:0] LEN_32B  = 3'b011;
    localparam logic [LEN_W-1:0] LEN_64B  = 3'b100;
    localparam logic [LEN_W-1:0] LEN_128B = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } rx_state_e;

    // Number of data flits following the address; reads carry no data.
    function automatic logic [CNT_W-1:0] words_from_length(
        input logic [CMD_W-1:0] cmd,
        input logic [LEN_W-1:0] len
    );
        if (cmd == CMD_RD_REQ) begin
            return '0;
        end
        return CNT_W'(1) << len;
    endfunction

endpackage

// File: rtl/rx_hdr_decode.sv
// Combinational header field extraction and legality check for one flit.
module rx_hdr_decode
    import chiplet_pkg::*;
(
    input  logic [FLIT_W-1:0] i_flit,
    output logic              o_mode,
    output logic              o_vld,
    output logic [CMD_W-1:0]  o_cmd,
    output logic [LEN_W-1:0]  o_len,
    output logic [ID_W-1:0]   o_tid,
    output logic [ID_W-1:0]   o_did,
    output logic [WORD_W-1:0] o_lw_addr,
    output logic              o_legal,
    output logic [CNT_W-1:0]  o_words
);

    logic w_cmd_ok;
    logic w_len_ok;

    assign o_mode    = i_flit[MODE_BIT];
    assign o_vld     = i_flit[VALID_BIT];
    assign o_cmd     = i_flit[CMD_LSB +: CMD_W];
    assign o_len     = i_flit[LEN_LSB +: LEN_W];
    assign o_tid     = i_flit[TID_LSB +: ID_W];
    assign o_did     = i_flit[DID_LSB +: ID_W];
    assign o_lw_addr = i_flit[LW_ADDR_LSB +: WORD_W];

    // Only the three defined commands and lengths up to 128B are accepted
    assign w_cmd_ok = (o_cmd == CMD_RD_REQ) || (o_cmd == CMD_WR_REQ) || (o_cmd == CMD_RD_RSP);
    assign w_len_ok = (o_len <= LEN_128B);
    assign o_legal  = w_cmd_ok && w_len_ok;
    assign o_words  = words_from_length(o_cmd, o_len);

endmodule

// File: rtl/slave_rx_flit_parser.sv
// Slave RX flit parser: pops flits from the RX link FIFO, decodes lightweight
// and extended headers and presents per-field registered outputs with valids.
module slave_rx_flit_parser
    import chiplet_pkg::*;
#(
    parameter int DATA_LINE_WIDTH = FLIT_W,
    parameter int WORD_SIZE       = WORD_W,
    parameter int MAX_WORDS       = MAX_PKT_WORDS
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_LINE_WIDTH-1:0] i_flit,
    input  logic                       i_flit_valid,
    output logic                       o_flit_ready,
    input  logic                       i_slave_rx_ready,
    output logic [CMD_W-1:0]           o_slave_rx_cmd,
    output logic                       o_slave_rx_cmd_valid,
    output logic [LEN_W-1:0]           o_slave_rx_length,
    output logic                       o_slave_rx_length_valid,
    output logic [ID_W-1:0]            o_slave_rx_tid,
    output logic                       o_slave_rx_tid_valid,
    output logic [ID_W-1:0]            o_slave_rx_did,
    output logic                       o_slave_rx_did_valid,
    output logic [WORD_SIZE-1:0]       o_slave_rx_addr,
    output logic                       o_slave_rx_addr_valid,
    output logic [WORD_SIZE-1:0]       o_slave_rx_data,
    output logic                       o_slave_rx_data_valid,
    output logic                       o_pkt_done,
    output logic                       o_hdr_err
);

    localparam int CW = $clog2(MAX_WORDS) + 1;

    rx_state_e r_state, w_nxt_state;
    logic [CW-1:0] r_cnt, w_nxt_cnt;

    logic                 w_accept;
    logic                 w_mode, w_vld, w_legal;
    logic [CMD_W-1:0]     w_cmd;
    logic [LEN_W-1:0]     w_len;
    logic [ID_W-1:0]      w_tid, w_did;
    logic [WORD_W-1:0]    w_lw_addr;
    logic [CNT_W-1:0]     w_words;

    logic w_hdr_ok, w_hdr_err, w_addr_ld, w_data_ld, w_done;
    logic [WORD_SIZE-1:0] w_addr_val;

    logic [CMD_W-1:0]     r_cmd;
    logic [LEN_W-1:0]     r_len;
    logic [ID_W-1:0]      r_tid, r_did;
    logic [WORD_SIZE-1:0] r_addr, r_data;
    logic                 r_hdr_vld, r_addr_vld, r_data_vld, r_done, r_err;

    // Popping is gated by reset so the FIFO is never drained while held in reset
    assign o_flit_ready = i_slave_rx_ready && rst_n;
    assign w_accept     = i_flit_valid && o_flit_ready;

    rx_hdr_decode u_hdr (
        .i_flit    (i_flit),
        .o_mode    (w_mode),
        .o_vld     (w_vld),
        .o_cmd     (w_cmd),
        .o_len     (w_len),
        .o_tid     (w_tid),
        .o_did     (w_did),
        .o_lw_addr (w_lw_addr),
        .o_legal   (w_legal),
        .o_words   (w_words)
    );

    // Lightweight headers carry the address inline; otherwise it is the flit payload
    assign w_addr_val = (r_state == ST_IDLE) ? WORD_SIZE'(w_lw_addr) : i_flit[WORD_SIZE-1:0];

    // State and word counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // Next-state decode and per-flit load strobes
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_hdr_ok    = 1'b0;
        w_hdr_err   = 1'b0;
        w_addr_ld   = 1'b0;
        w_data_ld   = 1'b0;
        w_done      = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    // Invalid-bit flits are idle fill and vanish without a trace
                    if (w_vld) begin
                        if (!w_legal) begin
                            w_hdr_err = 1'b1;
                        end else begin
                            w_hdr_ok  = 1'b1;
                            w_nxt_cnt = CW'(w_words);
                            if (w_mode) begin
                                w_nxt_state = ST_ADDR;
                            end else begin
                                w_addr_ld = 1'b1;
                                if (w_words == '0) begin
                                    w_done = 1'b1;
                                end else begin
                                    w_nxt_state = ST_DATA;
                                end
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    w_addr_ld = 1'b1;
                    if (r_cnt == '0) begin
                        w_done      = 1'b1;
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_state = ST_DATA;
                    end
                end
                ST_DATA: begin
                    w_data_ld = 1'b1;
                    w_nxt_cnt = r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        w_done      = 1'b1;
                        w_nxt_state = ST_IDLE;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    // Output registers: update only when downstream is ready, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd      <= '0;
            r_len      <= '0;
            r_tid      <= '0;
            r_did      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_hdr_vld  <= 1'b0;
            r_addr_vld <= 1'b0;
            r_data_vld <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else if (i_slave_rx_ready) begin
            r_hdr_vld  <= w_hdr_ok;
            r_addr_vld <= w_addr_ld;
            r_data_vld <= w_data_ld;
            r_done     <= w_done;
            r_err      <= w_hdr_err;
            if (w_hdr_ok) begin
                r_cmd <= w_cmd;
                r_len <= w_len;
                // Lightweight headers have no id fields
                r_tid <= w_mode ? w_tid : '0;
                r_did <= w_mode ? w_did : '0;
            end
            if (w_addr_ld) begin
                r_addr <= w_addr_val;
            end
            if (w_data_ld) begin
                r_data <= i_flit[WORD_SIZE-1:0];
            end
        end
    end

    assign o_slave_rx_cmd          = r_cmd;
    assign o_slave_rx_cmd_valid    = r_hdr_vld;
    assign o_slave_rx_length       = r_len;
    assign o_slave_rx_length_valid = r_hdr_vld;
    assign o_slave_rx_tid          = r_tid;
    assign o_slave_rx_tid_valid    = r_hdr_vld;
    assign o_slave_rx_did          = r_did;
    assign o_slave_rx_did_valid    = r_hdr_vld;
    assign o_slave_rx_addr         = r_addr;
    assign o_slave_rx_addr_valid   = r_addr_vld;
    assign o_slave_rx_data         = r_data;
    assign o_slave_rx_data_valid   = r_data_vld;
    assign o_pkt_done              = r_done;
    assign o_hdr_err               = r_err;

endmodule

// File: tb/tb_slave_rx_flit_parser.sv
// Directed table-driven bench for slave_rx_flit_parser.
module tb_slave_rx_flit_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] i_flit;
    logic        i_flit_valid;
    logic        o_flit_ready;
    logic        i_slave_rx_ready;
    logic [2:0]  cmd, len;
    logic [5:0]  tid, did;
    logic [31:0] addr, data;
    logic        cmd_v, len_v, tid_v, did_v, addr_v, data_v, done, err;

    slave_rx_flit_parser dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .i_flit                  (i_flit),
        .i_flit_valid            (i_flit_valid),
        .o_flit_ready            (o_flit_ready),
        .i_slave_rx_ready        (i_slave_rx_ready),
        .o_slave_rx_cmd          (cmd),
        .o_slave_rx_cmd_valid    (cmd_v),
        .o_slave_rx_length       (len),
        .o_slave_rx_length_valid (len_v),
        .o_slave_rx_tid          (tid),
        .o_slave_rx_tid_valid    (tid_v),
        .o_slave_rx_did          (did),
        .o_slave_rx_did_valid    (did_v),
        .o_slave_rx_addr         (addr),
        .o_slave_rx_addr_valid   (addr_v),
        .o_slave_rx_data         (data),
        .o_slave_rx_data_valid   (data_v),
        .o_pkt_done              (done),
        .o_hdr_err               (err)
    );

    always #5 clk = ~clk;

    // mask bits: header fields, addr, data, pkt_done, hdr_err
    localparam logic [4:0] H = 5'b10000, A = 5'b01000, D = 5'b00100, P = 5'b00010, E = 5'b00001;

    typedef struct {
        logic        rst_n, rdy, fv;
        logic [39:0] flit;
        logic [4:0]  m;
        logic [2:0]  cmd, len;
        logic [5:0]  tid, did;
        logic [31:0] addr, data;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    int   row   = 0;

    function automatic void add(input logic r, input logic rd, input logic fv, input logic [39:0] f,
                                input logic [4:0] m, input logic [2:0] c, input logic [2:0] l,
                                input logic [5:0] t, input logic [5:0] d,
                                input logic [31:0] a, input logic [31:0] dt);
        vec_t v;
        v.rst_n = r; v.rdy = rd; v.fv = fv; v.flit = f; v.m = m;
        v.cmd = c; v.len = l; v.tid = t; v.did = d; v.addr = a; v.data = dt;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
        end
    endtask

    initial begin
        logic [4:0] em;
        // reset with ready high: o_flit_ready must still be 0
        add(0,1,0,40'h0, 0,0,0,0,0,0,0);
        add(0,1,1,40'hFFDD000026, 0,0,0,0,0,0,0);
        // lightweight write, 2 words
        add(1,1,1,40'hFFDD000026, H|A, 1,1,0,0,32'hFFDD0000,0);
        add(1,1,1,40'h00000000AA, D, 0,0,0,0,0,32'hAA);
        add(1,1,1,40'h00000000BB, D|P, 0,0,0,0,0,32'hBB);
        // extended write tid=1 did=63 len=16B, backpressure mid-data
        add(1,1,1,40'h00000FC147, H, 1,2,6'h01,6'h3F,0,0);
        add(1,1,1,40'h0000000888, A, 0,0,0,0,32'h888,0);
        add(1,1,1,40'h0000001234, D, 0,0,0,0,0,32'h1234);
        add(1,0,1,40'h0000005678, D, 0,0,0,0,0,32'h1234);
        add(1,0,1,40'h0000005678, D, 0,0,0,0,0,32'h1234);
        add(1,0,1,40'h0000005678, D, 0,0,0,0,0,32'h1234);
        add(1,1,1,40'h0000005678, D, 0,0,0,0,0,32'h5678);
        add(1,1,1,40'h0000002444, D, 0,0,0,0,0,32'h2444);
        add(1,1,1,40'h0000003666, D|P, 0,0,0,0,0,32'h3666);
        // empty FIFO: valids clear
        add(1,1,0,40'h0000003666, 0, 0,0,0,0,0,0);
        // extended read request, then back-to-back lightweight RD_RSP
        add(1,1,1,40'h000001C203, H, 0,0,6'd2,6'd7,0,0);
        add(1,1,1,40'h0000000AAA, A|P, 0,0,0,0,32'hAAA,0);
        add(1,1,1,40'h123456780A, H|A, 2,0,0,0,32'h12345678,0);
        add(1,1,1,40'hFFDEADBEEF, D|P, 0,0,0,0,0,32'hDEADBEEF);
        // idle fill, illegal cmd, illegal length, then a good header
        add(1,1,1,40'h0000000000, 0, 0,0,0,0,0,0);
        add(1,1,1,40'h0000000000, 0, 0,0,0,0,0,0);
        add(1,1,1,40'h000000001E, E, 0,0,0,0,0,0);
        add(1,1,1,40'h00000000C6, E, 0,0,0,0,0,0);
        add(1,1,1,40'hCAFEF00D02, H|A|P, 0,0,0,0,32'hCAFEF00D,0);
        // extended write, 1 word: valid-bit-0 flits consumed as payload
        add(1,1,1,40'h0000024507, H, 1,0,6'd5,6'd9,0,0);
        add(1,1,1,40'h0000000000, A, 0,0,0,0,32'h0,0);
        add(1,1,1,40'h0000000000, D|P, 0,0,0,0,0,32'h0);
        // 32-word lightweight write: done only on the last word
        add(1,1,1,40'h00001000A6, H|A, 1,5,0,0,32'h1000,0);
        for (int i = 0; i < 32; i++) begin
            em = (i == 31) ? (D|P) : D;
            add(1,1,1,{8'h5A, 32'h100 + 32'(i)}, em, 0,0,0,0,0,32'h100 + 32'(i));
        end
        // reset mid-packet of a 32-word RD_RSP, then a fresh header
        add(1,1,1,40'h00000100AA, H|A, 2,5,0,0,32'h100,0);
        add(1,1,1,40'h0000000001, D, 0,0,0,0,0,32'h1);
        add(1,1,1,40'h0000000002, D, 0,0,0,0,0,32'h2);
        add(0,1,1,40'h0000000003, 0, 0,0,0,0,0,0);
        add(1,1,1,40'h000001C203, H, 0,0,6'd2,6'd7,0,0);
        add(1,1,1,40'h0000000AAA, A|P, 0,0,0,0,32'hAAA,0);

        foreach (tbl[i]) begin
            row              = i;
            rst_n            = tbl[i].rst_n;
            i_slave_rx_ready = tbl[i].rdy;
            i_flit_valid     = tbl[i].fv;
            i_flit           = tbl[i].flit;
            #1;
            chk("flit_ready", 64'(o_flit_ready), 64'(tbl[i].rdy & tbl[i].rst_n));
            @(posedge clk);
            #1;
            if (!tbl[i].rst_n) begin
                chk("rst_valids", 64'({cmd_v,len_v,tid_v,did_v,addr_v,data_v,done,err}), 64'(0));
                chk("rst_hdr", 64'({cmd,len,tid,did}), 64'(0));
                chk("rst_addr", 64'(addr), 64'(0));
                chk("rst_data", 64'(data), 64'(0));
            end else begin
                chk("valids", 64'({cmd_v,len_v,tid_v,did_v,addr_v,data_v,done,err}),
                    64'({tbl[i].m[4],tbl[i].m[4],tbl[i].m[4],tbl[i].m[4],tbl[i].m[3:0]}));
                if (tbl[i].m[4]) begin
                    chk("cmd", 64'(cmd), 64'(tbl[i].cmd));
                    chk("len", 64'(len), 64'(tbl[i].len));
                    chk("tid", 64'(tid), 64'(tbl[i].tid));
                    chk("did", 64'(did), 64'(tbl[i].did));
                end
                if (tbl[i].m[3]) chk("addr", 64'(addr), 64'(tbl[i].addr));
                if (tbl[i].m[2]) chk("data", 64'(data), 64'(tbl[i].data));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slave_rx_flit_parser.md
Name: slave_rx_flit_parser

Overview:
- Slave-side RX stage of chiplet_sys. Pops 40-bit flits from the slave RX link FIFO, decodes lightweight and extended packet headers, and emits per-field outputs: cmd, addr, data, tid, did and length, each with its own valid.
- Inverse of the master TX flit packetizer; its outputs drive the o_slave_rx_* interface of chiplet_sys.

Parameters:
- DATA_LINE_WIDTH, 40, flit width in bits; the design supports 40 only.
- WORD_SIZE, 32, payload bits per address or data flit.
- MAX_WORDS, 32, maximum data flits per packet (128B).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_flit  in  40  flit from RX FIFO head
- i_flit_valid  in  1  FIFO not empty
- o_flit_ready  out  1  pop strobe; a flit is accepted when i_flit_valid && o_flit_ready
- i_slave_rx_ready  in  1  downstream consumer ready
- o_slave_rx_cmd / o_slave_rx_cmd_valid  out  3 / 1  decoded command
- o_slave_rx_length / o_slave_rx_length_valid  out  3 / 1  length code
- o_slave_rx_tid / o_slave_rx_tid_valid  out  6 / 1  transaction id (0 for lightweight)
- o_slave_rx_did / o_slave_rx_did_valid  out  6 / 1  destination id (0 for lightweight)
- o_slave_rx_addr / o_slave_rx_addr_valid  out  32 / 1  address
- o_slave_rx_data / o_slave_rx_data_valid  out  32 / 1  one data word
- o_pkt_done  out  1  pulse with the last output of a packet
- o_hdr_err  out  1  pulse when a header is dropped

Behaviour:
- Reset: on rst_n==0 at posedge clk:
  - state=IDLE, word counter=0.
  - All outputs and valids are 0; o_flit_ready is 0 during reset.
- Header flit format:
  - [0] mode: 0 = lightweight, 1 = extended.
  - [1] valid.
  - [4:2] cmd: 000 RD_REQ, 001 WR_REQ, 010 RD_RSP.
  - [7:5] length: 000=4B, 001=8B, 010=16B, 011=32B, 100=64B, 101=128B.
  - Lightweight: [39:8] = address.
  - Extended: [13:8] tid, [19:14] did, [39:20] reserved (ignored).
- Address and data flits: payload in [31:0]; [39:32] ignored.
- Data word count = 1<<length for WR_REQ and RD_RSP; 0 for RD_REQ.
- Flow control:
  - o_flit_ready = i_slave_rx_ready && rst_n (combinational).
  - Each accepted flit updates the output registers at the next posedge: latency 1 cycle.
  - While i_slave_rx_ready==0, all outputs and valids hold their value.
  - When i_slave_rx_ready==1 and no flit is accepted, all valids clear.
- States:
  - IDLE, header accepted:
    - valid bit 0 → flit discarded silently (idle fill), no outputs.
    - cmd in {011..111} or length in {110,111} → flit discarded, o_hdr_err pulse, stay IDLE.
    - Otherwise → cmd, length, tid and did valid together.
    - Lightweight → addr_valid in the same cycle; go to DATA if word count > 0, else stay IDLE with o_pkt_done.
    - Extended → go to ADDR.
  - ADDR, flit accepted → addr_valid. Go to DATA, or to IDLE with o_pkt_done if word count == 0.
  - DATA, flit accepted → data_valid and counter--. On the last word, o_pkt_done and go to IDLE.
- A lightweight RD_RSP still emits addr_valid carrying header[39:8]; the consumer ignores it.
- Back-to-back packets: a header directly after the last data flit is accepted with no bubble.
- A flit whose valid bit is 0 inside ADDR or DATA is consumed as a payload flit. The valid bit is checked only in IDLE.
- Counter is 6 bits and is loaded with word count on header accept. It never wraps, because the maximum is 32.
- Reset mid-packet: the partial packet is abandoned, no o_pkt_done, state returns to IDLE. The next flit is parsed as a header.

Decomposition:
- Shared package chiplet_pkg:
  - cmd enum (CMD_RD_REQ, CMD_WR_REQ, CMD_RD_RSP).
  - length codes and a words_from_length function.
  - Header bit-position localparams (MODE_BIT, VALID_BIT, CMD_LSB, LEN_LSB, TID_LSB, DID_LSB, LW_ADDR_LSB).
  - Parser state enum.
- The master TX packetizer reuses the same package.
- One sub-module, rx_hdr_decode: combinational header field extraction plus legality check. The parser instantiates it.

Test Plan:
- Lightweight write:
  - Stimulus: flits 40'hFFDD000026, 40'h00000000AA, 40'h00000000BB, ready=1.
  - Response: cmd=1, len=1, addr=FFDD0000, tid=0, did=0; then data AA, then BB with o_pkt_done.
- Extended write:
  - Stimulus: header 40'h00000FC147 (tid=1, did=63, len=2), addr flit 0x888, data 1234, 5678, 2444, 3666.
  - Response: tid=01, did=3F, then addr 888, then 4 data beats; o_pkt_done on 3666.
- Extended read request:
  - Stimulus: header with tid=2, did=7, cmd=000, followed immediately by another header.
  - Response: addr AAA with o_pkt_done, no data_valid; the next header is decoded on the following cycle.
- Backpressure:
  - Stimulus: drop i_slave_rx_ready for 3 cycles during the data of the extended write.
  - Response: o_flit_ready=0 and outputs held; no word is lost or duplicated.
- Errors and idle fill:
  - Stimulus: 40'h0000000000 idle flits, then header cmd=111.
  - Response: nothing emitted for the idle flits; o_hdr_err pulses once for cmd=111; the following valid header parses normally.
- Reset mid-packet:
  - Stimulus: rst_n=0 after the 2nd data word of a 32-word RD_RSP.
  - Response: all outputs 0 next cycle, no o_pkt_done; the next flit is treated as a header.
